// File: rtl/drops_pkg.sv
// drops_pkg: shared definitions for the drops game controller.
//   drops_state_t : game state encoding (IDLE=0, PLAY=1, HIT=2, OVER=3)
//   LIVES_INIT    : lives loaded when a game starts
//   X_MAX_DFLT    : default rightmost legal bucket position
//   X_CENTER      : bucket start position for the default playfield
//   x_center()    : start position for an arbitrary playfield width
package drops_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_HIT  = 2'd2,
      ST_OVER = 2'd3
   } drops_state_t;

   localparam logic [1:0]  LIVES_INIT = 2'd3;
   localparam int unsigned X_MAX_DFLT = 624;

   function automatic logic [9:0] x_center(input int unsigned x_max);
      return 10'(x_max / 2);
   endfunction

   localparam logic [9:0] X_CENTER = x_center(X_MAX_DFLT);

endpackage

// File: rtl/drops_game_ctrl_if.sv
// drops_game_ctrl_if: signal bundle between the game environment (buttons,
// VGA frame pulse, renderer) and the game controller.
//   master modport : drives frame_tick, buttons and renderer events;
//                    observes the game outputs
//   slave modport  : the controller side
// Parameter SCORE_W sets the score width.
interface drops_game_ctrl_if #(
   parameter int unsigned SCORE_W = 8
) ();

   logic               frame_tick;
   logic               btn_left;
   logic               btn_right;
   logic               drop_hit;
   logic               drop_caught;
   logic [9:0]         player_x;
   logic [SCORE_W-1:0] score;
   logic [1:0]         lives;
   logic [1:0]         state;
   logic               spawn_en;
   logic               freeze;

   modport master (
      output frame_tick, btn_left, btn_right, drop_hit, drop_caught,
      input  player_x, score, lives, state, spawn_en, freeze
   );

   modport slave (
      input  frame_tick, btn_left, btn_right, drop_hit, drop_caught,
      output player_x, score, lives, state, spawn_en, freeze
   );

endinterface

// File: rtl/drops_btn_debounce.sv
// drops_btn_debounce: 2-flop synchronizer followed by a frame-sampled
// debouncer for one raw push button.
//   clk, rst    : system clock, synchronous active-high reset
//   frame_tick  : one-cycle sample strobe (once per video frame)
//   btn_raw     : asynchronous raw button level
//   btn_db      : debounced level; changes only on frame_tick, after
//                 DEB_FRAMES consecutive samples differing from it
module drops_btn_debounce #(
   parameter int unsigned DEB_FRAMES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_tick,
   input  logic btn_raw,
   output logic btn_db
);

   localparam int unsigned    CNT_W    = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_FRAMES - 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] cnt_q;
   logic             db_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         cnt_q  <= '0;
         db_q   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn_raw};
         if (frame_tick) begin
            // cnt_q holds how many consecutive prior samples disagreed
            if (sync_q[1] == db_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
               db_q  <= sync_q[1];
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign btn_db = db_q;

endmodule

// File: rtl/drops_game_ctrl.sv
// drops_game_ctrl: frame-rate game sequencer for the drops game.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : drops_game_ctrl_if.slave
//              in : frame_tick, btn_left, btn_right, drop_hit, drop_caught
//              out: player_x, score, lives, state, spawn_en, freeze
// Runs the IDLE/PLAY/HIT/OVER machine once per frame_tick, moves the bucket,
// keeps score and lives, and enables/freezes the drop datapath.
// Optional feature macro: DROPS_ACCEL_EN (double step after 8 held frames).
module drops_game_ctrl
   import drops_pkg::*;
#(
   parameter int unsigned X_MAX      = X_MAX_DFLT,
   parameter int unsigned STEP       = 4,
   parameter int unsigned DEB_FRAMES = 2,
   parameter int unsigned HIT_FRAMES = 60,
   parameter int unsigned SCORE_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   drops_game_ctrl_if.slave  bus
);

   localparam logic [9:0]         X_MID     = x_center(X_MAX);
   localparam logic [10:0]        X_LIM     = 11'(X_MAX);
   localparam logic [10:0]        STEP1     = 11'(STEP);
   localparam int unsigned        HC_W      = $clog2(HIT_FRAMES + 1);
   localparam logic [HC_W-1:0]    HC_LAST   = HC_W'(HIT_FRAMES - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   logic btn_l_db;
   logic btn_r_db;

   drops_btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_left (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (bus.frame_tick),
      .btn_raw    (bus.btn_left),
      .btn_db     (btn_l_db)
   );

   drops_btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_right (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (bus.frame_tick),
      .btn_raw    (bus.btn_right),
      .btn_db     (btn_r_db)
   );

   drops_state_t       state_q, state_d;
   logic [9:0]         x_q, x_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [1:0]         lives_q, lives_d;
   logic               hit_lat_q, hit_lat_d;
   logic [HC_W-1:0]    hit_cnt_q, hit_cnt_d;
   logic               rel_seen_q, rel_seen_d;
   logic               spawn_q, freeze_q;

   logic               hit_now;
   logic               any_btn, dir_l, dir_r;
   logic [10:0]        step_sel;
   logic [10:0]        x_ext, x_left, x_sum, x_right;

`ifdef DROPS_ACCEL_EN
   localparam logic [10:0] STEP2 = 11'(2 * STEP);
   logic [2:0] accel_q, accel_d;
`endif

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      score_d    = score_q;
      lives_d    = lives_q;
      hit_lat_d  = hit_lat_q;
      hit_cnt_d  = hit_cnt_q;
      rel_seen_d = rel_seen_q;

      // A hit arriving on the frame_tick cycle itself belongs to the ending frame
      hit_now = hit_lat_q | (bus.drop_hit & (state_q == ST_PLAY));
      any_btn = btn_l_db | btn_r_db;
      dir_l   = btn_l_db & ~btn_r_db;
      dir_r   = btn_r_db & ~btn_l_db;

`ifdef DROPS_ACCEL_EN
      step_sel = (accel_q == 3'd7) ? STEP2 : STEP1;
`else
      step_sel = STEP1;
`endif

      // 11-bit saturating arithmetic so neither edge can wrap
      x_ext   = {1'b0, x_q};
      x_left  = (x_ext < step_sel) ? '0 : (x_ext - step_sel);
      x_sum   = x_ext + step_sel;
      x_right = (x_sum > X_LIM) ? X_LIM : x_sum;

      if ((state_q == ST_PLAY) && bus.drop_caught && (score_q != SCORE_MAX))
         score_d = score_q + SCORE_W'(1);

      if (bus.frame_tick)
         hit_lat_d = 1'b0;
      else if ((state_q == ST_PLAY) && bus.drop_hit)
         hit_lat_d = 1'b1;

      if (bus.frame_tick) begin
         unique case (state_q)
            ST_IDLE: begin
               if (any_btn) begin
                  state_d = ST_PLAY;
                  score_d = '0;
                  lives_d = LIVES_INIT;
                  x_d     = X_MID;
               end
            end
            ST_PLAY: begin
               if (hit_now) begin
                  state_d   = ST_HIT;
                  lives_d   = (lives_q != 2'd0) ? (lives_q - 2'd1) : 2'd0;
                  hit_cnt_d = '0;
               end else if (dir_l) begin
                  x_d = x_left[9:0];
               end else if (dir_r) begin
                  x_d = x_right[9:0];
               end
            end
            ST_HIT: begin
               if (hit_cnt_q == HC_LAST) begin
                  hit_cnt_d = '0;
                  state_d   = (lives_q != 2'd0) ? ST_PLAY : ST_OVER;
               end else begin
                  hit_cnt_d = hit_cnt_q + HC_W'(1);
               end
            end
            ST_OVER: begin
               // A press only counts once a fully released frame has been seen
               if (rel_seen_q && any_btn)
                  state_d = ST_IDLE;
               else if (!any_btn)
                  rel_seen_d = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (state_d != ST_OVER)
         rel_seen_d = 1'b0;

`ifdef DROPS_ACCEL_EN
      accel_d = accel_q;
      if (bus.frame_tick) begin
         if ((state_q == ST_PLAY) && !hit_now && (dir_l || dir_r))
            accel_d = (accel_q == 3'd7) ? accel_q : (accel_q + 3'd1);
         else
            accel_d = '0;
      end
      if (state_d != ST_PLAY)
         accel_d = '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         x_q        <= X_MID;
         score_q    <= '0;
         lives_q    <= LIVES_INIT;
         hit_lat_q  <= 1'b0;
         hit_cnt_q  <= '0;
         rel_seen_q <= 1'b0;
         spawn_q    <= 1'b0;
         freeze_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         score_q    <= score_d;
         lives_q    <= lives_d;
         hit_lat_q  <= hit_lat_d;
         hit_cnt_q  <= hit_cnt_d;
         rel_seen_q <= rel_seen_d;
         spawn_q    <= (state_d == ST_PLAY);
         freeze_q   <= (state_d != ST_PLAY);
      end
   end

`ifdef DROPS_ACCEL_EN
   always_ff @(posedge clk) begin
      if (rst)
         accel_q <= '0;
      else
         accel_q <= accel_d;
   end
`endif

   assign bus.player_x = x_q;
   assign bus.score    = score_q;
   assign bus.lives    = lives_q;
   assign bus.state    = state_q;
   assign bus.spawn_en = spawn_q;
   assign bus.freeze   = freeze_q;

endmodule

// File: tb/tb_drops_game_ctrl.sv
// tb_drops_game_ctrl: directed scenarios plus randomized stimulus for
// drops_game_ctrl, checked every cycle against a frame-level game model,
// with literal expectations at the key scenario points.
module tb_drops_game_ctrl;
   import drops_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ft = 1'b0, bl = 1'b0, br = 1'b0, dh = 1'b0, dc = 1'b0;
   bit   chk_en = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   drops_game_ctrl_if #(.SCORE_W(8)) bus ();

   assign bus.frame_tick  = ft;
   assign bus.btn_left    = bl;
   assign bus.btn_right   = br;
   assign bus.drop_hit    = dh;
   assign bus.drop_caught = dc;

   drops_game_ctrl #(
      .X_MAX(624), .STEP(4), .DEB_FRAMES(2), .HIT_FRAMES(60), .SCORE_W(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- behavioural game model ----------------
   int m_state, m_x, m_score, m_lives, m_hitframes;
   bit m_hitlat, m_rel;
   bit m_s1l, m_s2l, m_s1r, m_s2r, m_dbl, m_dbr;
   int m_runl, m_runr;
   bit hit_now;

   always @(posedge clk) begin
      if (rst) begin
         m_state = 0; m_x = 312; m_score = 0; m_lives = 3; m_hitframes = 0;
         m_hitlat = 0; m_rel = 0;
         m_s1l = 0; m_s2l = 0; m_s1r = 0; m_s2r = 0; m_dbl = 0; m_dbr = 0;
         m_runl = 0; m_runr = 0;
      end else begin
         hit_now = m_hitlat || (dh && m_state == 1);
         if (m_state == 1 && dc && m_score < 255) m_score = m_score + 1;
         if (ft) begin
            m_hitlat = 0;
            case (m_state)
               0: if (m_dbl || m_dbr) begin
                     m_state = 1; m_score = 0; m_lives = 3; m_x = 312;
                  end
               1: if (hit_now) begin
                     m_state = 2; m_lives = m_lives - 1; m_hitframes = 0;
                  end else if (m_dbl && !m_dbr) begin
                     m_x = (m_x - 4 < 0) ? 0 : m_x - 4;
                  end else if (m_dbr && !m_dbl) begin
                     m_x = (m_x + 4 > 624) ? 624 : m_x + 4;
                  end
               2: begin
                     m_hitframes = m_hitframes + 1;
                     if (m_hitframes == 60) m_state = (m_lives != 0) ? 1 : 3;
                  end
               default: begin
                     if (m_rel && (m_dbl || m_dbr)) m_state = 0;
                     else if (!m_dbl && !m_dbr) m_rel = 1;
                  end
            endcase
            if (m_state != 3) m_rel = 0;
            if (m_s2l == m_dbl) m_runl = 0;
            else begin
               m_runl = m_runl + 1;
               if (m_runl == 2) begin m_dbl = m_s2l; m_runl = 0; end
            end
            if (m_s2r == m_dbr) m_runr = 0;
            else begin
               m_runr = m_runr + 1;
               if (m_runr == 2) begin m_dbr = m_s2r; m_runr = 0; end
            end
         end else if (dh && m_state == 1) begin
            m_hitlat = 1;
         end
         m_s2l = m_s1l; m_s1l = bl;
         m_s2r = m_s1r; m_s1r = br;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("state",    32'(bus.state),    m_state);
         chk("player_x", 32'(bus.player_x), m_x);
         chk("score",    32'(bus.score),    m_score);
         chk("lives",    32'(bus.lives),    m_lives);
         chk("spawn_en", 32'(bus.spawn_en), (m_state == 1) ? 1 : 0);
         chk("freeze",   32'(bus.freeze),   (m_state != 1) ? 1 : 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input logic t);
      ft = t;
      @(negedge clk);
      ft = 1'b0;
      dc = 1'b0;
   endtask

   task automatic frame();
      repeat ($urandom_range(2, 5)) cyc(1'b0);
      cyc(1'b1);
   endtask

   task automatic expect_reset_vals(input string tag);
      chk({tag, "_state"},  32'(bus.state),    0);
      chk({tag, "_x"},      32'(bus.player_x), 312);
      chk({tag, "_score"},  32'(bus.score),    0);
      chk({tag, "_lives"},  32'(bus.lives),    3);
      chk({tag, "_spawn"},  32'(bus.spawn_en), 0);
      chk({tag, "_freeze"}, 32'(bus.freeze),   1);
   endtask

   initial begin
      int cd;
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cd;
      // reset
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      expect_reset_vals("rst");

      // left press: PLAY after debounce, then first move
      bl = 1'b1;
      frame(); frame();
      chk("start_idle", 32'(bus.state), 0);
      frame();
      chk("start_play", 32'(bus.state), 1);
      chk("start_x", 32'(bus.player_x), 312);
      frame();
      chk("first_move", 32'(bus.player_x), 308);
      bl = 1'b0;
      repeat (3) frame();

      // catches, hit on the tick cycle, catch during HIT
      repeat (5) begin dc = 1'b1; cyc(1'b0); end
      chk("score5", 32'(bus.score), 5);
      dh = 1'b1; cyc(1'b1); dh = 1'b0;
      chk("hit_state", 32'(bus.state), 2);
      chk("hit_lives", 32'(bus.lives), 2);
      chk("hit_freeze", 32'(bus.freeze), 1);
      dc = 1'b1; cyc(1'b0);
      chk("score_hold_hit", 32'(bus.score), 5);
      repeat (59) frame();
      chk("hit_59", 32'(bus.state), 2);
      frame();
      chk("hit_done", 32'(bus.state), 1);

      // right held: saturate at the right edge
      br = 1'b1;
      repeat (200) frame();
      chk("x_sat", 32'(bus.player_x), 624);

      // two more hits (one latched between ticks) -> OVER
      dh = 1'b1; cyc(1'b0); dh = 1'b0;
      frame();
      chk("hit2_lives", 32'(bus.lives), 1);
      repeat (60) frame();
      chk("hit2_done", 32'(bus.state), 1);
      dh = 1'b1; cyc(1'b1); dh = 1'b0;
      chk("hit3_lives", 32'(bus.lives), 0);
      repeat (60) frame();
      chk("over_state", 32'(bus.state), 3);
      chk("over_lives", 32'(bus.lives), 0);
      repeat (3) frame();
      bl = 1'b1;
      repeat (3) frame();
      chk("over_held", 32'(bus.state), 3);
      bl = 1'b0; br = 1'b0;
      repeat (4) frame();
      chk("over_rel", 32'(bus.state), 3);
      br = 1'b1;
      repeat (3) frame();
      chk("to_idle", 32'(bus.state), 0);
      chk("idle_score", 32'(bus.score), 5);
      frame();
      chk("replay_state", 32'(bus.state), 1);
      chk("replay_lives", 32'(bus.lives), 3);
      chk("replay_score", 32'(bus.score), 0);
      br = 1'b0;

      // reset in HIT coincident with frame_tick
      dh = 1'b1; cyc(1'b1); dh = 1'b0;
      chk("pre_rst_hit", 32'(bus.state), 2);
      repeat (3) frame();
      rst = 1'b1; ft = 1'b1;
      @(negedge clk);
      rst = 1'b0; ft = 1'b0;
      expect_reset_vals("rst_hit");

      // randomized play
      cd = 3;
      for (int i = 0; i < 6000; i++) begin
         if (cd == 0) begin ft = 1'b1; cd = $urandom_range(2, 6); end
         else begin ft = 1'b0; cd--; end
         if ($urandom_range(0, 39) == 0) bl = ~bl;
         if ($urandom_range(0, 29) == 0) br = ~br;
         dc  = ($urandom_range(0, 5) == 0);
         dh  = ($urandom_range(0, 249) == 0);
         rst = ($urandom_range(0, 2999) == 0);
         @(negedge clk);
      end
      ft = 1'b0; bl = 1'b0; br = 1'b0; dc = 1'b0; dh = 1'b0; rst = 1'b0;
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/drops_game_ctrl.md
# drops_game_ctrl

Frame-rate game sequencer for the drops game. Sits between the raw player buttons, the VGA timing generator's frame pulse and the drop renderer/collision logic. It debounces left/right inputs, moves the player bucket, keeps score and lives, and runs the IDLE/PLAY/HIT/OVER state machine that enables or freezes the drop datapath.

## Interface

- X_MAX, 624: rightmost legal player_x (10-bit).
- STEP, 4: player movement in pixels per frame.
- DEB_FRAMES, 2: consecutive frame samples required to accept a button level.
- HIT_FRAMES, 60: frames spent in HIT.
- SCORE_W, 8: score width.

Ports:

- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- frame_tick  in  1  one-cycle pulse at the start of vertical blanking.
- btn_left  in  1  raw left button, asynchronous.
- btn_right  in  1  raw right button, asynchronous.
- drop_hit  in  1  renderer collision between player and a hazard drop; level or pulse.
- drop_caught  in  1  one-cycle pulse per drop caught.
- player_x  out  10  bucket left edge.
- score  out  SCORE_W  caught-drop count.
- lives  out  2  remaining lives.
- state  out  2  IDLE=0, PLAY=1, HIT=2, OVER=3.
- spawn_en  out  1  drop generator enable.
- freeze  out  1  hold all drop motion.

## Operation

- **Input path:** each button passes through a 2-flop synchronizer and then the debouncer. The debounced level changes only at frame_tick, and only after DEB_FRAMES consecutive equal samples.
- **hit_lat:** set by drop_hit while in PLAY. Cleared at every frame_tick, after the FSM has evaluated it. A drop_hit in the same cycle as frame_tick is counted for the ending frame.
- **FSM:** evaluated only on frame_tick.
  - IDLE → PLAY on either debounced button pressed. Entering PLAY loads score=0, lives=3 and player_x=X_MAX/2 (312).
  - PLAY → HIT when hit_lat=1. lives decrements in the same update. Movement is suppressed in that frame.
  - HIT: counts HIT_FRAMES frames. Then goes to PLAY if lives≠0, else OVER.
  - OVER waits until both buttons are debounced-released for at least one frame, then a press moves it to IDLE. Score and lives hold through OVER and IDLE.
- **Movement (PLAY only, on frame_tick):**
  - left only: player_x = max(0, player_x−STEP).
  - right only: player_x = min(X_MAX, player_x+STEP).
  - both or neither: hold.
  - Saturation is computed in 11-bit arithmetic; no wrap.
- **Score:** each drop_caught pulse in PLAY adds 1 and saturates at 2^SCORE_W−1. Pulses are ignored in other states. A catch and a hit in the same frame are both applied.
- **Drop datapath control:** spawn_en = (state==PLAY); freeze = (state!=PLAY).

## Timing

- All outputs are registered. State, player_x and lives update on the clk edge after the frame_tick cycle. Score updates the cycle after drop_caught.
- Button to movement latency: 2 clocks of sync, plus DEB_FRAMES frames, plus 1 frame.
- Reset values: state=IDLE, player_x=312, score=0, lives=3, spawn_en=0, freeze=1, hit_lat=0, HIT counter=0, debouncers released.
- rst asserted mid-game overrides everything on the next edge, including a coincident frame_tick.
- frame_tick stuck high: the FSM advances once per clock. This is legal but is not a supported use.

## Configuration

- **DROPS_ACCEL_EN defined:** a held direction counts frames (3-bit, saturating). From the 8th consecutive held frame onward the step is 2·STEP. The count clears on release, on both buttons pressed, or on leaving PLAY.
- **DROPS_ACCEL_EN undefined:** the step is always STEP, and the counter logic is absent.

## Structure

- **drops_pkg:** state encoding as typedef, LIVES_INIT=3, and X_CENTER=X_MAX/2.
- **drops_btn_debounce:** one sub-module containing the synchronizer and frame-sampled debouncer, instantiated twice (left, right).
- **drops_game_ctrl:** the FSM, the movement/score/lives registers, and the optional accel counter.

## Test plan

- Reset, then a left press held 3 frames. Expected: state goes to PLAY after DEB_FRAMES frames; player_x=312, then 308 on the next frame.
- Right held for 200 frames. Expected: player_x saturates at 624 and never wraps; with DROPS_ACCEL_EN, increments become 8 from the 8th held frame.
- 5 drop_caught pulses in PLAY, plus 1 during HIT. Expected: score=5.
- drop_hit coincident with frame_tick in PLAY. Expected: next cycle state=HIT, lives=2, freeze=1; after 60 frames state=PLAY.
- Three hits. Expected: state=OVER with lives=0; a press while a button is still held stays in OVER; release then press goes to IDLE.
- rst asserted in HIT, on the same cycle as frame_tick. Expected: all outputs return to their reset values on the next edge.
